// File: rtl/hs_pkg.sv
// Shared helpers for the elastic pipeline: depth limit, clog2 and pointer type.
package hs_pkg;

  localparam int HS_MAX_DEPTH = 64;

  function automatic int hs_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // Wide enough for any FIFO pointer up to HS_MAX_DEPTH-1 slots.
  typedef logic [hs_clog2(HS_MAX_DEPTH-1)-1:0] hs_ptr_t;

  function automatic hs_ptr_t hs_ptr_inc(input hs_ptr_t p, input hs_ptr_t last);
    return (p == last) ? '0 : p + hs_ptr_t'(1);
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Register-array storage for the elastic pipe's FIFO slots; async read.
module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ENTRIES = 1,
  parameter int PW      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [PW-1:0]     wr_ptr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PW-1:0]     rd_ptr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_i] <= data_i;
    end
  end

  assign data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/hs_elastic_pipe.sv
// Elastic valid/ready stage: registered output slot plus DEPTH-1 FIFO slots, all outputs flopped.
// Optional HS_LEVEL_EN adds a registered occupancy port level_o.
module hs_elastic_pipe
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  output logic [DATA_W-1:0] data_o
`ifdef HS_LEVEL_EN
  ,
  output logic [hs_clog2(DEPTH+1)-1:0] level_o
`endif
);

  localparam int PW = (hs_clog2(DEPTH-1) < 1) ? 1 : hs_clog2(DEPTH-1);
  localparam int CW = hs_clog2(DEPTH+1);
  localparam hs_ptr_t PTR_LAST = hs_ptr_t'(DEPTH-2);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, wr_nxt, rd_nxt;
  logic [CW-1:0]     fcnt_q, fcnt_d, cnt, cnt_d;
  logic              push, pop, wr_en;
  logic [DATA_W-1:0] fifo_rdata;

  assign push = valid_pre_i & ready_q;
  assign pop  = valid_q & ready_post_i;
  assign cnt  = fcnt_q + CW'(valid_q);

  assign wr_nxt = PW'(hs_ptr_inc(hs_ptr_t'(wr_q), PTR_LAST));
  assign rd_nxt = PW'(hs_ptr_inc(hs_ptr_t'(rd_q), PTR_LAST));

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fcnt_d  = fcnt_q;
    wr_en   = 1'b0;
    if (!valid_q || pop) begin
      if (fcnt_q != '0) begin
        valid_d = 1'b1;
        data_d  = fifo_rdata;
        rd_d    = rd_nxt;
        fcnt_d  = fcnt_q - CW'(1);
        if (push) begin
          wr_en  = 1'b1;
          wr_d   = wr_nxt;
          fcnt_d = fcnt_q;
        end
      end else if (push) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        valid_d = 1'b0;
      end
    end else if (push) begin
      wr_en  = 1'b1;
      wr_d   = wr_nxt;
      fcnt_d = fcnt_q + CW'(1);
    end
  end

  // Ready looks only at the next occupancy, so a pop while full frees the slot one cycle later.
  always_comb begin
    cnt_d = cnt;
    if (push && !pop)      cnt_d = cnt + CW'(1);
    else if (pop && !push) cnt_d = cnt - CW'(1);
    ready_d = (cnt_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  hs_fifo_mem #(.DATA_W(DATA_W), .ENTRIES(DEPTH-1), .PW(PW)) u_mem (
    .clk     (clk),
    .rst     (reset),
    .wr_en_i (wr_en),
    .wr_ptr_i(wr_q),
    .data_i  (data_i),
    .rd_ptr_i(rd_q),
    .data_o  (fifo_rdata)
  );

`ifdef HS_LEVEL_EN
  logic [CW-1:0] level_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else       level_q <= cnt_d;
  end
  assign level_o = level_q;
`endif

  assign valid_post_o = valid_q;
  assign data_o       = data_q;
  assign ready_pre_o  = ready_q;

endmodule

// File: tb/tb_hs_elastic_pipe.sv
// Bench for hs_elastic_pipe: DEPTH=4 directed/table checks and DEPTH=3 random scoreboard run.
module tb_hs_elastic_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v4, r4, rp4, vo4;
  logic [7:0] d4, do4;
  logic       v3, r3, rp3, vo3;
  logic [7:0] d3, do3;
`ifdef HS_LEVEL_EN
  logic [2:0] lvl4;
  logic [1:0] lvl3;
`endif

  hs_elastic_pipe #(.DATA_W(8), .DEPTH(4)) u4 (
    .clk(clk), .reset(rst), .valid_pre_i(v4), .ready_pre_o(rp4), .data_i(d4),
    .valid_post_o(vo4), .ready_post_i(r4), .data_o(do4)
`ifdef HS_LEVEL_EN
    , .level_o(lvl4)
`endif
  );

  hs_elastic_pipe #(.DATA_W(8), .DEPTH(3)) u3 (
    .clk(clk), .reset(rst), .valid_pre_i(v3), .ready_pre_o(rp3), .data_i(d3),
    .valid_post_o(vo3), .ready_post_i(r3), .data_o(do3)
`ifdef HS_LEVEL_EN
    , .level_o(lvl3)
`endif
  );

  int chk_n  = 0;
  int pass_n = 0;
  int max3   = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard on the handshake seen before the edge, then advance one cycle.
  task automatic step();
    if (vo4 && r4) begin
      if (q4.size() == 0) chk("sb4_unexpected_pop", 1, 0);
      else chk("sb4_data", do4, q4.pop_front());
    end
    if (v4 && rp4) q4.push_back(d4);
    if (vo3 && r3) begin
      if (q3.size() == 0) chk("sb3_unexpected_pop", 1, 0);
      else chk("sb3_data", do3, q3.pop_front());
    end
    if (v3 && rp3) q3.push_back(d3);
    @(posedge clk);
    #1;
    if (q3.size() > max3) max3 = q3.size();
  endtask

  typedef struct {
    logic       v, r;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       erdy;
    logic [2:0] elvl;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic v, logic r, logic [7:0] d, logic ev, logic [7:0] ed,
                              logic erdy, logic [2:0] elvl);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.ev = ev; t.ed = ed; t.erdy = erdy; t.elvl = elvl;
    return t;
  endfunction

  initial begin
    // fill, stall, single pop, refill, then drain with no pushes (DEPTH=4)
    tbl[0]  = mk(1, 0, 8'hA0, 1, 8'hA0, 1, 1);
    tbl[1]  = mk(1, 0, 8'hA1, 1, 8'hA0, 1, 2);
    tbl[2]  = mk(1, 0, 8'hA2, 1, 8'hA0, 1, 3);
    tbl[3]  = mk(1, 0, 8'hA3, 1, 8'hA0, 0, 4);
    tbl[4]  = mk(1, 0, 8'hA4, 1, 8'hA0, 0, 4);
    tbl[5]  = mk(1, 1, 8'hA4, 1, 8'hA1, 1, 3);
    tbl[6]  = mk(1, 0, 8'hA4, 1, 8'hA1, 0, 4);
    tbl[7]  = mk(0, 1, 8'h00, 1, 8'hA2, 1, 3);
    tbl[8]  = mk(0, 1, 8'h00, 1, 8'hA3, 1, 2);
    tbl[9]  = mk(0, 1, 8'h00, 1, 8'hA4, 1, 1);
    tbl[10] = mk(0, 1, 8'h00, 0, 8'hA4, 1, 0);

    rst = 1'b1;
    v4 = 0; r4 = 0; d4 = 0; v3 = 0; r3 = 0; d3 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", vo4, 0);
    chk("rst_data", do4, 0);
    chk("rst_ready", rp4, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready_low", rp4, 0);
    step();
    chk("ready_after_release", rp4, 1);
`ifdef HS_LEVEL_EN
    chk("level_reset", lvl4, 0);
`endif

    // back-to-back stream, one cycle latency, never stalls
    r4 = 1;
    for (int i = 1; i <= 16; i++) begin
      v4 = 1; d4 = 8'(i);
      chk("t1_ready", rp4, 1);
      step();
      chk("t1_valid", vo4, 1);
      chk("t1_data", do4, i);
    end
    v4 = 0;
    step();
    chk("t1_idle_valid", vo4, 0);
    chk("t1_idle_hold", do4, 8'h10);

    for (int i = 0; i < 11; i++) begin
      v4 = tbl[i].v; r4 = tbl[i].r; d4 = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_valid", i), vo4, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), do4, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), rp4, tbl[i].erdy);
`ifdef HS_LEVEL_EN
      chk($sformatf("tbl%0d_level", i), lvl4, tbl[i].elvl);
`endif
    end

    // reset with three entries held discards them
    r4 = 0; v4 = 1;
    d4 = 8'h11; step();
    d4 = 8'h22; step();
    d4 = 8'h33; step();
    v4 = 0;
    chk("t5_held_data", do4, 8'h11);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", vo4, 0);
    chk("t5_rst_data", do4, 0);
    chk("t5_rst_ready", rp4, 0);
    q4.delete();
    q3.delete();
    step();
    rst = 1'b0;
    step();
    chk("t5_ready_back", rp4, 1);
    v4 = 1; r4 = 1; d4 = 8'h55;
    step();
    v4 = 0;
    chk("t5_valid55", vo4, 1);
    chk("t5_data55", do4, 8'h55);
    step();
    chk("t5_alone", vo4, 0);
`ifdef HS_LEVEL_EN
    chk("t5_level", lvl4, 0);
`endif

    // random handshakes on the non-power-of-two depth
    max3 = 0;
    for (int i = 0; i < 10000; i++) begin
      v3 = 1'($urandom_range(0, 1));
      r3 = 1'($urandom_range(0, 1));
      d3 = 8'($urandom);
      step();
    end
    v3 = 0; r3 = 1;
    for (int i = 0; i < 6; i++) step();
    chk("t4_count_le3", (max3 <= 3), 1);
    chk("t4_reached_full", max3, 3);
    chk("t4_drained", q3.size(), 0);
    chk("t4_idle_valid", vo3, 0);
    chk("t4_ready", rp3, 1);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
